vip_frame_fifo: RTL and testbench

Parametrised multi-channel synchronous FIFO. It is the successor to the fixed input/output FIFOs around the conv core.
- Stores NUM_CHANNEL_IN packed DWIDTH-bit channel words per entry.
- Adds programmable almost-full/almost-empty margins, an occupancy count, and sticky overflow/underflow flags.
- Tags each stored pixel with start-of-frame and end-of-frame bits derived from a WIDTH x HEIGHT write-side pixel counter.
- Sits between the host stream and core, and between core and output stream.

---
 rtl/vip_frame_fifo_if.sv | 40 ++++
 rtl/vip_frame_fifo.sv | 141 ++++++++++++++
 tb/tb_vip_frame_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vip_frame_fifo_if.sv
// Purpose: write/read handshake, data and status bundle for vip_frame_fifo.
// Latency: none (wires only).
// Backpressure: producer watches full/almost_full, consumer watches empty/almost_empty.
interface vip_frame_fifo_if #(
  parameter int DWIDTH         = 32,
  parameter int NUM_CHANNEL_IN = 8,
  parameter int DEPTH          = 16
);
  localparam int DW = NUM_CHANNEL_IN * DWIDTH;
  localparam int UW = $clog2(DEPTH) + 1;

  logic          clear;
  logic [DW-1:0] data;
  logic          wrreq;
  logic          rdreq;
  logic [DW-1:0] q;
  logic          q_sop;
  logic          q_eop;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [UW-1:0] usedw;
  logic          overflow;
  logic          underflow;

  // Stream side that pushes/pops entries and observes status.
  modport master (
    output clear, data, wrreq, rdreq,
    input  q, q_sop, q_eop, full, empty, almost_full, almost_empty,
           usedw, overflow, underflow
  );

  // The FIFO itself.
  modport slave (
    input  clear, data, wrreq, rdreq,
    output q, q_sop, q_eop, full, empty, almost_full, almost_empty,
           usedw, overflow, underflow
  );
endinterface

// File: rtl/vip_frame_fifo.sv
// Purpose: multi-channel sync FIFO tagging each pixel with frame sop/eop bits.
// Latency: q one edge after rd_ok; with VIP_FIFO_SHOWAHEAD_EN, q shows the head entry.
// Backpressure: writes at full and reads at empty are dropped and set sticky flags.
module vip_frame_fifo #(
  parameter int DWIDTH         = 32,
  parameter int NUM_CHANNEL_IN = 8,
  parameter int DEPTH          = 16,
  parameter int AF_MARGIN      = 2,
  parameter int AE_MARGIN      = 1,
  parameter int WIDTH          = 56,
  parameter int HEIGHT         = 56
) (
  input  logic             clock,
  input  logic             resetn,
  vip_frame_fifo_if.slave  f
);
  localparam int DW    = NUM_CHANNEL_IN * DWIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int FRAME = WIDTH * HEIGHT;
  localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [AW:0]   USED_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   USED_AF   = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [AW:0]   USED_AE   = (AW+1)'(AE_MARGIN);
  localparam logic [CW-1:0] PIX_LAST  = CW'(FRAME - 1);

  // Entry layout: {eop, sop, data}
  logic [DW+1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   usedw_r;
  logic [CW-1:0] pix_cnt;
  logic          ovf_r;
  logic          udf_r;
  logic          full_w;
  logic          empty_w;
  logic          wr_ok;
  logic          rd_ok;
  logic [DW+1:0] head;

  // All flags come from the registered occupancy, never from this cycle's requests.
  assign full_w  = (usedw_r == USED_FULL);
  assign empty_w = (usedw_r == '0);

  // clear wins over both requests in the same cycle.
  assign wr_ok = f.wrreq & ~full_w  & ~f.clear;
  assign rd_ok = f.rdreq & ~empty_w & ~f.clear;

  assign head = mem[rd_ptr];

  assign f.full         = full_w;
  assign f.empty        = empty_w;
  assign f.almost_full  = (usedw_r >= USED_AF);
  assign f.almost_empty = (usedw_r <= USED_AE);
  assign f.usedw        = usedw_r;
  assign f.overflow     = ovf_r;
  assign f.underflow    = udf_r;

  // Store accepted pixel with its frame position tags.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {(pix_cnt == PIX_LAST), (pix_cnt == '0), f.data};
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); usedw tracks exact occupancy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_r <= '0;
    end else if (f.clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_r <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   usedw_r <= usedw_r + (AW+1)'(1);
        2'b01:   usedw_r <= usedw_r - (AW+1)'(1);
        default: usedw_r <= usedw_r;
      endcase
    end
  end

  // Write-side pixel position within the frame; only accepted writes advance it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_cnt <= '0;
    end else if (f.clear) begin
      pix_cnt <= '0;
    end else if (wr_ok) begin
      pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + CW'(1);
    end
  end

  // Sticky error flags, only cleared by reset or clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else if (f.clear) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (f.wrreq && full_w)  ovf_r <= 1'b1;
      if (f.rdreq && empty_w) udf_r <= 1'b1;
    end
  end

`ifdef VIP_FIFO_SHOWAHEAD_EN
  logic [DW+1:0] q_hold;

  // Remember the head so q keeps its last value once the FIFO runs dry.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q_hold <= '0;
    end else if (!empty_w) begin
      q_hold <= head;
    end
  end

  assign {f.q_eop, f.q_sop, f.q} = empty_w ? q_hold : head;
`else
  logic [DW+1:0] q_r;

  // Registered read: capture the head on each accepted pop, hold otherwise.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q_r <= '0;
    end else if (rd_ok) begin
      q_r <= head;
    end
  end

  assign {f.q_eop, f.q_sop, f.q} = q_r;
`endif

endmodule

// File: tb/tb_vip_frame_fifo.sv
// Purpose: directed table-driven and sequence checks of vip_frame_fifo (registered-read build).
// Latency: expects q one edge after each accepted read.
// Backpressure: exercises writes at full, reads at empty, clear and async reset.
module tb_vip_frame_fifo;
  localparam int DWIDTH = 32;
  localparam int NCH    = 8;
  localparam int DEPTH  = 16;
  localparam int DW     = NCH * DWIDTH;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  vip_frame_fifo_if #(.DWIDTH(DWIDTH), .NUM_CHANNEL_IN(NCH), .DEPTH(DEPTH)) bus ();

  vip_frame_fifo #(
    .DWIDTH(DWIDTH), .NUM_CHANNEL_IN(NCH), .DEPTH(DEPTH),
    .AF_MARGIN(2), .AE_MARGIN(1), .WIDTH(4), .HEIGHT(2)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .f     (bus)
  );

  typedef struct {
    string        name;
    bit           clr;
    bit           wr;
    bit           rd;
    logic [7:0]   widx;
    logic [10:0]  st;
    bit           chk_q;
    logic [7:0]   qidx;
    bit           sop;
    bit           eop;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // Channel c of word idx = {16'hC0DE, c, idx}; channel 0 in the LSBs.
  function automatic logic [DW-1:0] word(input logic [7:0] idx);
    logic [DW-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*32 +: 32] = {16'hC0DE, 8'(c), idx};
    return w;
  endfunction

  // {usedw, full, empty, almost_full, almost_empty, overflow, underflow}
  function automatic logic [10:0] st_exp(input int u, input bit ovf, input bit udf);
    return {5'(u), (u == 16), (u == 0), (u >= 14), (u <= 1), ovf, udf};
  endfunction

  function automatic logic [10:0] st_now();
    return {bus.usedw, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
            bus.overflow, bus.underflow};
  endfunction

  function automatic vec_t mk(input string name, input bit clr, input bit wr, input bit rd,
                              input logic [7:0] widx, input int u, input bit ovf, input bit udf,
                              input bit chk_q, input logic [7:0] qidx, input bit sop, input bit eop);
    vec_t v;
    v.name = name; v.clr = clr; v.wr = wr; v.rd = rd; v.widx = widx;
    v.st = st_exp(u, ovf, udf);
    v.chk_q = chk_q; v.qidx = qidx; v.sop = sop; v.eop = eop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [259:0] got, input logic [259:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic cycle(input bit clr, input bit wr, input bit rd, input logic [7:0] idx);
    @(negedge clock);
    bus.clear = clr;
    bus.wrreq = wr;
    bus.rdreq = rd;
    bus.data  = word(idx);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    @(negedge clock);
    bus.clear = 1'b0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[$];
    logic [7:0] sb[$];
    logic [7:0] exp_q;
    logic [7:0] idx;
    bit         wr, rd, exp_wr, exp_rd;

    bus.clear = 1'b0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    bus.data  = '0;

    // Fill / drain with frame tags (frame = 8 pixels)
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk($sformatf("fill%0d", i), 0, 1, 0, 8'(i), i + 1, 0, 0, 0, 8'd0, 0, 0));
    tbl.push_back(mk("fill_over", 0, 1, 0, 8'd16, 16, 1, 0, 0, 8'd0, 0, 0));
    for (int j = 0; j < 16; j++)
      tbl.push_back(mk($sformatf("drain%0d", j), 0, 0, 1, 8'd0, 15 - j, 1, 0,
                       1, 8'(j), (j % 8) == 0, (j % 8) == 7));
    tbl.push_back(mk("drain_under", 0, 0, 1, 8'd0, 0, 1, 1, 1, 8'd15, 0, 1));
    tbl.push_back(mk("clear_a", 1, 0, 0, 8'd0, 0, 0, 0, 1, 8'd15, 0, 1));
    // Frame tagging over 10 pixels
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk($sformatf("tag_wr%0d", k), 0, 1, 0, 8'(8'h20 + k), k + 1, 0, 0, 0, 8'd0, 0, 0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk($sformatf("tag_rd%0d", k), 0, 0, 1, 8'd0, 9 - k, 0, 0,
                       1, 8'(8'h20 + k), (k % 8) == 0, k == 7));
    tbl.push_back(mk("clear_b", 1, 0, 0, 8'd0, 0, 0, 0, 1, 8'h29, 0, 0));
    // Concurrent read+write at usedw=5
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk($sformatf("conc_pre%0d", k), 0, 1, 0, 8'(8'h40 + k), k + 1, 0, 0, 0, 8'd0, 0, 0));
    for (int k = 0; k < 20; k++)
      tbl.push_back(mk($sformatf("conc%0d", k), 0, 1, 1, 8'(8'h45 + k), 5, 0, 0,
                       1, 8'(8'h40 + k), (k % 8) == 0, (k % 8) == 7));

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset status", 260'(st_now()), 260'(st_exp(0, 0, 0)));
    chk("reset q", 260'({bus.q_sop, bus.q_eop, bus.q}), 260'(0));
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      bus.clear = tbl[i].clr;
      bus.wrreq = tbl[i].wr;
      bus.rdreq = tbl[i].rd;
      bus.data  = word(tbl[i].widx);
      @(posedge clock);
      #1;
      chk({tbl[i].name, " status"}, 260'(st_now()), 260'(tbl[i].st));
      if (tbl[i].chk_q)
        chk({tbl[i].name, " q"}, 260'({bus.q_sop, bus.q_eop, bus.q}),
            260'({tbl[i].sop, tbl[i].eop, word(tbl[i].qidx)}));
    end
    idle();

    // Clear while writing at usedw=9
    cycle(1, 0, 0, 8'd0);
    chk("t5 pre-clear", 260'(st_now()), 260'(st_exp(0, 0, 0)));
    cycle(0, 0, 1, 8'd0);
    chk("t5 empty read", 260'(st_now()), 260'(st_exp(0, 0, 1)));
    for (int k = 0; k < 9; k++) cycle(0, 1, 0, 8'(8'h60 + k));
    chk("t5 usedw9", 260'(st_now()), 260'(st_exp(9, 0, 1)));
    cycle(1, 1, 0, 8'h70);
    chk("t5 clear while writing", 260'(st_now()), 260'(st_exp(0, 0, 0)));
    cycle(0, 1, 0, 8'h71);
    chk("t5 write after clear", 260'(st_now()), 260'(st_exp(1, 0, 0)));
    cycle(0, 0, 1, 8'd0);
    chk("t5 sop after clear", 260'({bus.q_sop, bus.q_eop, bus.q}), 260'({1'b1, 1'b0, word(8'h71)}));
    chk("t5 drained", 260'(st_now()), 260'(st_exp(0, 0, 0)));

    // Async reset in the middle of a write burst
    cycle(0, 1, 0, 8'h80);
    cycle(0, 1, 0, 8'h81);
    chk("burst usedw2", 260'(st_now()), 260'(st_exp(2, 0, 0)));
    #2;
    resetn = 1'b0;
    #1;
    chk("async reset status", 260'(st_now()), 260'(st_exp(0, 0, 0)));
    chk("async reset q", 260'({bus.q_sop, bus.q_eop, bus.q}), 260'(0));
    idle();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("post reset empty", 260'(st_now()), 260'(st_exp(0, 0, 0)));

    // Random interleaved traffic across pointer wrap
    for (int i = 0; i < 40; i++) begin
      wr  = (i < 24) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd  = (i < 24) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) != 0);
      idx = 8'($urandom_range(0, 255));
      exp_wr = wr && (sb.size() < DEPTH);
      exp_rd = rd && (sb.size() > 0);
      exp_q  = 8'd0;
      cycle(0, wr, rd, idx);
      if (exp_rd) exp_q = sb.pop_front();
      if (exp_wr) sb.push_back(idx);
      chk($sformatf("rand%0d usedw", i), 260'(bus.usedw), 260'(sb.size()));
      chk($sformatf("rand%0d bound", i), 260'(bus.usedw <= 5'd16), 260'(1));
      if (exp_rd) chk($sformatf("rand%0d q", i), 260'(bus.q), 260'(word(exp_q)));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
